// File: rtl/rr_dispatch_pkg.sv
// Shared types and default frame geometry for the round-robin pixel dispatcher.
package rr_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int DEF_X_MAX = 639;
    localparam int DEF_Y_MAX = 479;

endpackage

// File: rtl/rr_dispatch_xy_scan_counter.sv
// Raster scan counter: steps (x,y) in line order on enable, returns to (0,0) after the last pixel.
module xy_scan_counter #(
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          enable,
    input  logic          clear,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] XLAST = XW'(X_MAX);
    localparam logic [YW-1:0] YLAST = YW'(Y_MAX);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (enable) begin
            if (x_q == XLAST) begin
                x_d = '0;
                y_d = (y_q == YLAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == XLAST) && (y_q == YLAST);

endmodule

// File: rtl/rr_dispatch.sv
// Hands frame pixels to idle workers in round-robin order, one grant per cycle, then waits for all to finish.
module rr_dispatch
    import rr_dispatch_pkg::*;
#(
    parameter int NUM_W = 16,
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_MAX = DEF_Y_MAX
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start,
    input  logic [NUM_W-1:0]          jw_dp_ready,
    output logic [NUM_W-1:0]          dp_jw_start,
    output logic [NUM_W-1:0][XW-1:0]  x_reg,
    output logic [NUM_W-1:0][YW-1:0]  y_reg,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int PW = (NUM_W > 1) ? $clog2(NUM_W) : 1;

    state_e                   state_q;
    logic [PW-1:0]            rr_ptr_q;
    logic [NUM_W-1:0]         claimed_q, claimed_d;
    logic [NUM_W-1:0]         start_q;
    logic [NUM_W-1:0][XW-1:0] x_q;
    logic [NUM_W-1:0][YW-1:0] y_q;
    logic                     busy_q;
    logic                     done_q;

    logic [NUM_W-1:0]         eligible;
    logic [PW:0]              pick;
    logic                     grant_vld;
    logic [PW-1:0]            grant_idx;
    logic                     search_grant;
    logic [NUM_W-1:0]         grant_oh;

    logic [XW-1:0]            scan_x;
    logic [YW-1:0]            scan_y;
    logic                     scan_last;

    // First set bit of elig at or after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [PW:0] rr_pick(input logic [NUM_W-1:0] elig,
                                            input logic [PW-1:0]    ptr);
        logic [PW:0]   res;
        logic [PW-1:0] sel;
        int            idx;
        res = '0;
        for (int i = 0; i < NUM_W; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_W) begin
                idx = idx - NUM_W;
            end
            sel = PW'(idx);
            if (!res[PW] && elig[sel]) begin
                res = {1'b1, sel};
            end
        end
        return res;
    endfunction

    always_comb begin
        eligible     = jw_dp_ready & ~claimed_q;
        pick         = rr_pick(eligible, rr_ptr_q);
        grant_vld    = pick[PW];
        grant_idx    = pick[PW-1:0];
        search_grant = (state_q == ST_SEARCH) && grant_vld;
        grant_oh     = '0;
        grant_oh[grant_idx] = search_grant;
    end

    // A claim lasts until the worker is seen not ready, so a slow ready drop cannot earn a second pixel.
    always_comb begin
        claimed_d = (claimed_q & jw_dp_ready) | grant_oh;
    end

    xy_scan_counter #(
        .XW    (XW),
        .YW    (YW),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_scan (
        .clk    (clk),
        .n_rst  (n_rst),
        .enable (search_grant),
        .clear  (state_q == ST_IDLE),
        .x      (scan_x),
        .y      (scan_y),
        .last   (scan_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            claimed_q <= '0;
            start_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            claimed_q <= claimed_d;
            start_q   <= grant_oh;
            done_q    <= 1'b0;

            if (search_grant) begin
                x_q[grant_idx] <= scan_x;
                y_q[grant_idx] <= scan_y;
                rr_ptr_q       <= (grant_idx == PW'(NUM_W - 1)) ? '0 : grant_idx + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SEARCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SEARCH: begin
                    if (search_grant && scan_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((&jw_dp_ready) && (claimed_q == '0)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dp_jw_start = start_q;
    assign x_reg       = x_q;
    assign y_reg       = y_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_rr_dispatch.sv
// Scoreboard bench for rr_dispatch on a 4-worker, 4x2 frame.
module tb_rr_dispatch;

    localparam int NW = 4;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int XM = 3;
    localparam int YM = 1;

    logic                   clk   = 1'b0;
    logic                   n_rst = 1'b1;
    logic                   start = 1'b0;
    logic [NW-1:0]          ready = '1;
    logic [NW-1:0]          dp_jw_start;
    logic [NW-1:0][XW-1:0]  x_reg;
    logic [NW-1:0][YW-1:0]  y_reg;
    logic                   busy;
    logic                   frame_done;

    rr_dispatch #(
        .NUM_W (NW),
        .XW    (XW),
        .YW    (YW),
        .X_MAX (XM),
        .Y_MAX (YM)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .jw_dp_ready (ready),
        .dp_jw_start (dp_jw_start),
        .x_reg       (x_reg),
        .y_reg       (y_reg),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int px;
        int py;
        bit b2b;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   last_cyc  = -10;
    int   grant_cnt = 0;
    int   exp_done  = 0;
    bit   model_en  = 1'b0;
    int   cnt[NW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every issue pulse and every frame_done must match the scoreboard.
    initial begin
        forever begin
            int   w;
            exp_t e;
            @(negedge clk);
            if (dp_jw_start != '0) begin
                grant_cnt++;
                chk("issue_onehot", $countones(dp_jw_start), 1);
                w = 0;
                for (int k = 0; k < NW; k++) if (dp_jw_start[k]) w = k;
                if (sb_q.size() == 0) begin
                    chk("unexpected_issue_worker", w, -1);
                end else begin
                    e = sb_q.pop_front();
                    chk("issue_worker", w, e.w);
                    chk("issue_x", int'(x_reg[w]), e.px);
                    chk("issue_y", int'(y_reg[w]), e.py);
                    if (e.b2b) chk("issue_gap_cycles", cyc - last_cyc, 1);
                end
                last_cyc = cyc;
            end
            if (frame_done) begin
                chk("frame_done_expected", (exp_done > 0) ? 1 : 0, 1);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    // Worker model: ready drops one cycle after its start pulse and returns three cycles later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (model_en) begin
                for (int k = 0; k < NW; k++) begin
                    if (cnt[k] > 0) begin
                        cnt[k]++;
                        if (cnt[k] == 2) ready[k] = 1'b0;
                        if (cnt[k] == 5) begin
                            ready[k] = 1'b1;
                            cnt[k]   = 0;
                        end
                    end
                    if (dp_jw_start[k]) cnt[k] = 1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=%0d required=0", sb_q.size());
        $fatal(1, "watchdog");
    end

    task automatic push(input int w, input int px, input int py, input bit b2b);
        exp_t e;
        e = '{w: w, px: px, py: py, b2b: b2b};
        sb_q.push_back(e);
    endtask

    task automatic push_frame();
        for (int yi = 0; yi <= YM; yi++)
            for (int xi = 0; xi <= XM; xi++)
                push(xi, xi, yi, xi != 0);
        exp_done++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int lim);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < lim) begin
            tick(1);
            n++;
        end
        chk(name, sb_q.size(), 0);
    endtask

    task automatic wait_done(input string name, input int lim);
        int n;
        n = 0;
        while (exp_done != 0 && n < lim) begin
            tick(1);
            n++;
        end
        chk(name, exp_done, 0);
    endtask

    task automatic clear_model();
        model_en = 1'b0;
        for (int k = 0; k < NW; k++) cnt[k] = 0;
        ready = '1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        start = 1'b0;
        clear_model();
        tick(2);
        sb_q.delete();
        exp_done = 0;
        n_rst = 1'b1;
        tick(1);
    endtask

    initial begin
        int g0;
        int n;
        for (int k = 0; k < NW; k++) cnt[k] = 0;
        #1 n_rst = 1'b0;
        tick(2);
        chk("rst_issue", int'(dp_jw_start), 0);
        chk("rst_x", int'(x_reg), 0);
        chk("rst_y", int'(y_reg), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        n_rst = 1'b1;
        tick(1);

        // All ready held high: four back-to-back grants, then claims block re-grants.
        for (int xi = 0; xi <= XM; xi++) push(xi, xi, 0, xi != 0);
        pulse_start();
        tick(1);
        chk("busy_in_search", int'(busy), 1);
        wait_empty("allready_issue_timeout", 20);
        g0 = grant_cnt;
        tick(6);
        chk("claimed_blocks_regrant", grant_cnt - g0, 0);
        chk("issue_zero_when_idle", int'(dp_jw_start), 0);

        // Only worker 2 ready with rr_ptr at 3: the grant wraps to worker 2.
        do_reset();
        ready = 4'b0111;
        for (int xi = 0; xi < 3; xi++) push(xi, xi, 0, xi != 0);
        pulse_start();
        wait_empty("wrap_setup_timeout", 20);
        push(2, 3, 0, 1'b0);
        ready = 4'b0000;
        tick(1);
        ready = 4'b0100;
        wait_empty("wrap_issue_timeout", 10);
        chk("wrap_x0_held", int'(x_reg[0]), 0);
        chk("wrap_x1_held", int'(x_reg[1]), 1);
        chk("wrap_x2_new", int'(x_reg[2]), 3);
        chk("wrap_x3_held", int'(x_reg[3]), 0);
        chk("wrap_y2_new", int'(y_reg[2]), 0);

        // Full frame with modelled workers.
        do_reset();
        model_en = 1'b1;
        g0 = grant_cnt;
        push_frame();
        pulse_start();
        wait_empty("frame_issue_timeout", 40);
        wait_done("frame_done_timeout", 40);
        chk("frame_issue_total", grant_cnt - g0, 8);
        tick(1);
        chk("busy_after_frame", int'(busy), 0);

        // Reset after five grants aborts the frame.
        g0 = grant_cnt;
        push_frame();
        pulse_start();
        n = 0;
        while (grant_cnt - g0 < 5 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_five_grants", grant_cnt - g0, 5);
        n_rst = 1'b0;
        #1;
        chk("abort_issue_zero", int'(dp_jw_start), 0);
        chk("abort_x_zero", int'(x_reg), 0);
        chk("abort_y_zero", int'(y_reg), 0);
        chk("abort_busy_zero", int'(busy), 0);
        chk("abort_done_zero", int'(frame_done), 0);
        clear_model();
        sb_q.delete();
        exp_done = 0;
        tick(2);
        n_rst = 1'b1;
        g0 = grant_cnt;
        tick(10);
        chk("abort_no_activity", grant_cnt - g0, 0);
        chk("abort_busy_idle", int'(busy), 0);
        model_en = 1'b1;
        push_frame();
        pulse_start();
        wait_empty("restart_issue_timeout", 40);
        wait_done("restart_done_timeout", 40);

        // start held through DRAIN/DONE: one pulse for frame one, then a second frame.
        g0 = grant_cnt;
        push_frame();
        push_frame();
        start = 1'b1;
        n = 0;
        while (exp_done > 1 && n < 60) begin
            tick(1);
            n++;
        end
        chk("held_start_first_done", exp_done, 1);
        tick(3);
        start = 1'b0;
        wait_empty("second_frame_issue_timeout", 80);
        wait_done("second_frame_done_timeout", 80);
        chk("held_start_issue_total", grant_cnt - g0, 16);
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
